match_timer: RTL and testbench

//  Parametrised match-flow engine for the pong game, clocked by the slow clk_26 tick domain.

---
 rtl/match_timer_pkg.sv | 26 ++
 rtl/match_timer_if.sv | 33 +++
 rtl/match_timer_tick_prescaler.sv | 43 ++++
 rtl/match_timer.sv | 192 +++++++++++++++++++
 tb/tb_match_timer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/match_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_timer_pkg                                                            |
// | Phase encodings and phase helpers shared by the match-flow engine.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package match_timer_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE      = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_PLAY      = 3'd2,
    PH_PAUSED    = 3'd3,
    PH_OVERTIME  = 3'd4,
    PH_GAMEOVER  = 3'd5
  } phase_e;

  // Phases in which the ball and paddles move.
  function automatic logic is_playing(input phase_e p);
    return (p == PH_PLAY) || (p == PH_OVERTIME);
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_timer_if                                                             |
// | Control/status bundle between the game top and the match-flow engine.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface match_timer_if #(
  parameter int SEC_W = 7
);
  logic                          start;
  logic                          pause;
  logic                          win_reached;
  logic                          scores_tied;
  logic [SEC_W-1:0]              duration_sel;
  match_timer_pkg::phase_e       phase;
  logic [SEC_W-1:0]              seconds;
  logic [SEC_W-1:0]              countdown;
  logic                          play_en;
  logic                          game_over;
  logic                          timeout;
  logic                          hold_done;

  modport master (
    output start, pause, win_reached, scores_tied, duration_sel,
    input  phase, seconds, countdown, play_en, game_over, timeout, hold_done
  );

  modport slave (
    input  start, pause, win_reached, scores_tied, duration_sel,
    output phase, seconds, countdown, play_en, game_over, timeout, hold_done
  );
endinterface
`default_nettype wire

// File: rtl/match_timer_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tick_prescaler                                                             |
// | Divides clk_26 into game-second ticks; sync clear, stalls when disabled.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tick_prescaler #(
  parameter int MODULUS = 1
) (
  input  wire logic clk_26,
  input  wire logic reset,
  input  wire logic i_en,
  input  wire logic i_clr,
  output logic      o_tick
);

  generate
    if (MODULUS <= 1) begin : g_passthru
      logic w_unused;
      assign w_unused = clk_26 ^ reset ^ i_clr;
      assign o_tick   = i_en;
    end else begin : g_count
      localparam int                c_cnt_w = $clog2(MODULUS);
      localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MODULUS - 1);

      logic [c_cnt_w-1:0] r_cnt;
      logic [c_cnt_w-1:0] w_cnt_eff;

      // A clear makes this cycle count as the first one of the new phase.
      assign w_cnt_eff = i_clr ? '0 : r_cnt;
      assign o_tick    = i_en && (w_cnt_eff == c_last);

      always_ff @(posedge clk_26 or posedge reset) begin
        if (reset)       r_cnt <= '0;
        else if (!i_en)  r_cnt <= w_cnt_eff;
        else if (o_tick) r_cnt <= '0;
        else             r_cnt <= w_cnt_eff + c_cnt_w'(1);
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/match_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_timer                                                                |
// | Match flow: IDLE -> COUNTDOWN -> PLAY (pausable) -> GAMEOVER hold -> IDLE. |
// | Optional overtime on tied expiry: define MATCH_OVERTIME_EN.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module match_timer
  import match_timer_pkg::*;
#(
  parameter int SEC_W          = 7,
  parameter int DEFAULT_SECS   = 60,
  parameter int COUNTDOWN_SECS = 3,
  parameter int HOLD_SECS      = 3,
  parameter int TICKS_PER_SEC  = 1,
  parameter int OT_SECS        = 15
) (
  input  wire logic     clk_26,
  input  wire logic     reset,
  match_timer_if.slave  io_mt
);

  localparam int               c_hold_w       = (HOLD_SECS > 1) ? $clog2(HOLD_SECS) : 1;
  localparam logic [SEC_W-1:0] c_default_secs = SEC_W'(DEFAULT_SECS);
  localparam logic [SEC_W-1:0] c_cd_secs      = SEC_W'(COUNTDOWN_SECS);
  localparam logic [SEC_W-1:0] c_one          = SEC_W'(1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_SECS - 1);

  phase_e              r_phase;
  phase_e              r_phase_prev;
  phase_e              r_resume;
  logic [SEC_W-1:0]    r_seconds;
  logic [SEC_W-1:0]    r_countdown;
  logic [c_hold_w-1:0] r_hold;
  logic                r_play_en;
  logic                r_game_over;
  logic                r_timeout;
  logic                r_hold_done;
  logic                r_start_q;
  logic                r_pause_q;

  logic                w_start_edge;
  logic                w_pause_edge;
  logic [SEC_W-1:0]    w_eff_dur;
  logic                w_tick;
  logic                w_presc_en;
  logic                w_presc_clr;

  assign w_start_edge = io_mt.start & ~r_start_q;
  assign w_pause_edge = io_mt.pause & ~r_pause_q;
  assign w_eff_dur    = (io_mt.duration_sel == '0) ? c_default_secs : io_mt.duration_sel;
  assign w_presc_en   = (r_phase != PH_IDLE) && (r_phase != PH_PAUSED);
  assign w_presc_clr  = (r_phase != r_phase_prev);

`ifndef MATCH_OVERTIME_EN
  logic w_unused;
  assign w_unused = io_mt.scores_tied ^ (OT_SECS == 0);
`endif

  tick_prescaler #(
    .MODULUS (TICKS_PER_SEC)
  ) u_prescaler (
    .clk_26 (clk_26),
    .reset  (reset),
    .i_en   (w_presc_en),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk_26 or posedge reset) begin
    if (reset) r_phase_prev <= PH_IDLE;
    else       r_phase_prev <= r_phase;
  end

  // Edge registers reset high so a level held across reset release is not an edge.
  always_ff @(posedge clk_26 or posedge reset) begin
    if (reset) begin
      r_phase     <= PH_IDLE;
      r_resume    <= PH_PLAY;
      r_seconds   <= c_default_secs;
      r_countdown <= '0;
      r_hold      <= '0;
      r_play_en   <= 1'b0;
      r_game_over <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_done <= 1'b0;
      r_start_q   <= 1'b1;
      r_pause_q   <= 1'b1;
    end else begin
      r_start_q   <= io_mt.start;
      r_pause_q   <= io_mt.pause;
      r_hold_done <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          r_seconds <= w_eff_dur;
          if (w_start_edge) begin
            if (COUNTDOWN_SECS == 0) begin
              r_phase   <= PH_PLAY;
              r_play_en <= 1'b1;
            end else begin
              r_phase     <= PH_COUNTDOWN;
              r_countdown <= c_cd_secs;
            end
          end
        end

        PH_GAMEOVER: begin
          if (w_tick) begin
            if (r_hold == c_hold_last) begin
              r_phase     <= PH_IDLE;
              r_hold      <= '0;
              r_game_over <= 1'b0;
              r_timeout   <= 1'b0;
              r_hold_done <= 1'b1;
              r_seconds   <= w_eff_dur;
            end else begin
              r_hold <= r_hold + c_hold_w'(1);
            end
          end
        end

        PH_COUNTDOWN, PH_PLAY, PH_PAUSED, PH_OVERTIME: begin
          if (io_mt.win_reached) begin
            r_phase     <= PH_GAMEOVER;
            r_hold      <= '0;
            r_countdown <= '0;
            r_play_en   <= 1'b0;
            r_game_over <= 1'b1;
            r_timeout   <= 1'b0;
          end else if (w_start_edge) begin
            r_phase     <= PH_IDLE;
            r_countdown <= '0;
            r_play_en   <= 1'b0;
            r_seconds   <= w_eff_dur;
          end else if (w_pause_edge && (r_phase == PH_PAUSED)) begin
            r_phase   <= r_resume;
            r_play_en <= 1'b1;
          end else if (w_pause_edge && is_playing(r_phase)) begin
            r_phase   <= PH_PAUSED;
            r_resume  <= r_phase;
            r_play_en <= 1'b0;
          end else if (w_tick && (r_phase == PH_COUNTDOWN)) begin
            if (r_countdown <= c_one) begin
              r_phase     <= PH_PLAY;
              r_countdown <= '0;
              r_play_en   <= 1'b1;
            end else begin
              r_countdown <= r_countdown - c_one;
            end
          end else if (w_tick && is_playing(r_phase)) begin
            if (r_seconds > c_one) begin
              r_seconds <= r_seconds - c_one;
            end else begin
              r_seconds <= '0;
`ifdef MATCH_OVERTIME_EN
              if ((r_phase == PH_PLAY) && io_mt.scores_tied) begin
                r_phase   <= PH_OVERTIME;
                r_seconds <= SEC_W'(OT_SECS);
              end else
`endif
              begin
                r_phase     <= PH_GAMEOVER;
                r_hold      <= '0;
                r_play_en   <= 1'b0;
                r_game_over <= 1'b1;
                r_timeout   <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_phase     <= PH_IDLE;
          r_countdown <= '0;
          r_play_en   <= 1'b0;
          r_game_over <= 1'b0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  assign io_mt.phase     = r_phase;
  assign io_mt.seconds   = r_seconds;
  assign io_mt.countdown = r_countdown;
  assign io_mt.play_en   = r_play_en;
  assign io_mt.game_over = r_game_over;
  assign io_mt.timeout   = r_timeout;
  assign io_mt.hold_done = r_hold_done;

endmodule
`default_nettype wire

// File: tb/tb_match_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_match_timer                                                             |
// | Directed scenarios plus random stimulus against a behavioural match model. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_match_timer;

  localparam int SEC_W = 7;
  localparam int DEF   = 5;
  localparam int CD    = 3;
  localparam int HOLD  = 3;
  localparam int TPS   = 2;
  localparam int OT    = 2;

  localparam int P_IDLE = 0, P_CD = 1, P_PLAY = 2, P_PAUSED = 3, P_OT = 4, P_GO = 5;

  logic clk_26 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_26 = ~clk_26;

  match_timer_if #(.SEC_W(SEC_W)) mif();

  match_timer #(
    .SEC_W(SEC_W), .DEFAULT_SECS(DEF), .COUNTDOWN_SECS(CD),
    .HOLD_SECS(HOLD), .TICKS_PER_SEC(TPS), .OT_SECS(OT)
  ) dut (
    .clk_26 (clk_26),
    .reset  (reset),
    .io_mt  (mif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: phase, clocks in seconds, and cycles spent in the current phase.
  int m_phase, m_secs, m_cd, m_hold_ticks, m_sub, m_resume;
  bit m_timeout, m_hd, m_prev_s, m_prev_p;

  logic             drv_start, drv_pause, drv_win, drv_tied;
  logic [SEC_W-1:0] drv_dsel;

  function automatic int eff_dur(input int d);
    return (d == 0) ? DEF : d;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_secs = DEF; m_cd = 0; m_hold_ticks = 0; m_sub = 0;
    m_resume = P_PLAY; m_timeout = 0; m_hd = 0; m_prev_s = 1; m_prev_p = 1;
  endtask

  task automatic model_step(input bit s, input bit p, input bit w, input bit t, input int d);
    bit s_edge, p_edge, en, tick;
    int nph;
    s_edge = s && !m_prev_s;
    p_edge = p && !m_prev_p;
    en     = (m_phase != P_IDLE) && (m_phase != P_PAUSED);
    tick   = en && ((m_sub % TPS) == TPS - 1);
    nph    = m_phase;
    m_hd   = 0;
    if (m_phase == P_IDLE) begin
      m_secs = eff_dur(d);
      if (s_edge) begin
        nph  = (CD == 0) ? P_PLAY : P_CD;
        m_cd = CD;
      end
    end else if (m_phase == P_GO) begin
      if (tick) begin
        m_hold_ticks++;
        if (m_hold_ticks >= HOLD) begin
          nph = P_IDLE; m_hd = 1; m_timeout = 0; m_secs = eff_dur(d);
        end
      end
    end else if (w) begin
      nph = P_GO; m_timeout = 0; m_hold_ticks = 0;
    end else if (s_edge) begin
      nph = P_IDLE; m_secs = eff_dur(d);
    end else if (p_edge && m_phase == P_PAUSED) begin
      nph = m_resume;
    end else if (p_edge && (m_phase == P_PLAY || m_phase == P_OT)) begin
      m_resume = m_phase; nph = P_PAUSED;
    end else if (tick && m_phase == P_CD) begin
      m_cd--;
      if (m_cd == 0) nph = P_PLAY;
    end else if (tick) begin
      m_secs = (m_secs > 0) ? m_secs - 1 : 0;
      if (m_secs == 0) begin
`ifdef MATCH_OVERTIME_EN
        if (m_phase == P_PLAY && t) begin
          nph = P_OT; m_secs = OT;
        end else begin
          nph = P_GO; m_timeout = 1; m_hold_ticks = 0;
        end
`else
        nph = P_GO; m_timeout = 1; m_hold_ticks = 0;
        if (t) m_hold_ticks = 0;
`endif
      end
    end
    if (nph != P_CD) m_cd = 0;
    m_sub    = (nph != m_phase) ? 0 : (en ? m_sub + 1 : m_sub);
    m_phase  = nph;
    m_prev_s = s;
    m_prev_p = p;
  endtask

  // Apply the current drive values for one cycle, then compare at the falling edge.
  task automatic step();
    mif.start = drv_start; mif.pause = drv_pause; mif.win_reached = drv_win;
    mif.scores_tied = drv_tied; mif.duration_sel = drv_dsel;
    model_step(drv_start, drv_pause, drv_win, drv_tied, int'(drv_dsel));
    @(negedge clk_26);
    check_value("phase",     int'(mif.phase),     m_phase);
    check_value("seconds",   int'(mif.seconds),   m_secs);
    check_value("countdown", int'(mif.countdown), m_cd);
    check_value("play_en",   int'(mif.play_en),   (m_phase == P_PLAY || m_phase == P_OT) ? 1 : 0);
    check_value("game_over", int'(mif.game_over), (m_phase == P_GO) ? 1 : 0);
    check_value("timeout",   int'(mif.timeout),   int'(m_timeout));
    check_value("hold_done", int'(mif.hold_done), int'(m_hd));
  endtask

  task automatic wait_phase(input int target, input int budget, output int n);
    n = 0;
    while (int'(mif.phase) != target && n < budget) begin
      step();
      n++;
    end
    if (int'(mif.phase) != target) check_value("wait_phase_budget", int'(mif.phase), target);
  endtask

  task automatic wait_secs(input int target, input int budget);
    int n = 0;
    while (int'(mif.seconds) != target && n < budget) begin
      step();
      n++;
    end
    if (int'(mif.seconds) != target) check_value("wait_secs_budget", int'(mif.seconds), target);
  endtask

  task automatic check_reset_values(input string tag);
    check_value({tag, "_phase"},   int'(mif.phase),     P_IDLE);
    check_value({tag, "_seconds"}, int'(mif.seconds),   DEF);
    check_value({tag, "_cd"},      int'(mif.countdown), 0);
    check_value({tag, "_flags"},   int'({mif.play_en, mif.game_over, mif.timeout, mif.hold_done}), 0);
  endtask

  task automatic start_match(input int dsel);
    drv_start = 1'b0; step();
    drv_dsel  = SEC_W'(dsel); drv_start = 1'b1; step();
  endtask

  initial begin
    int n;
    model_reset();
    drv_start = 1'b1; drv_pause = 1'b1; drv_win = 1'b0; drv_tied = 1'b0; drv_dsel = '0;
    mif.start = 1'b1; mif.pause = 1'b1; mif.win_reached = 1'b0;
    mif.scores_tied = 1'b0; mif.duration_sel = '0;
    repeat (2) @(negedge clk_26);
    check_reset_values("reset");
    #1 reset = 1'b0;

    // Start and pause held through reset release do not fire.
    repeat (4) step();
    check_value("held_start_idle", int'(mif.phase), P_IDLE);

    // Default-length match expiring on the clock, then the GAMEOVER hold.
    drv_pause = 1'b0;
    start_match(0);
    wait_phase(P_PLAY, 40, n);
    check_value("cd_cycles", n, CD * TPS);
    wait_phase(P_GO, 60, n);
    check_value("play_cycles", n, DEF * TPS);
    check_value("expiry_timeout", int'(mif.timeout), 1);
    check_value("expiry_seconds", int'(mif.seconds), 0);
    wait_phase(P_IDLE, 40, n);
    check_value("hold_cycles", n, HOLD * TPS);
    check_value("hold_done_pulse", int'(mif.hold_done), 1);
    step();
    check_value("hold_done_single", int'(mif.hold_done), 0);

    // Win during play freezes the clock.
    start_match(10);
    wait_phase(P_PLAY, 40, n);
    wait_secs(7, 40);
    drv_win = 1'b1; step();
    check_value("win_phase", int'(mif.phase), P_GO);
    check_value("win_timeout", int'(mif.timeout), 0);
    check_value("win_seconds", int'(mif.seconds), 7);
    drv_win = 1'b0;
    wait_phase(P_IDLE, 40, n);

    // Pause holds seconds; resume continues; start edge aborts.
    start_match(10);
    wait_phase(P_PLAY, 40, n);
    wait_secs(8, 40);
    drv_pause = 1'b1; step();
    drv_pause = 1'b0; repeat (4) step();
    check_value("paused_phase", int'(mif.phase), P_PAUSED);
    check_value("paused_seconds", int'(mif.seconds), 8);
    drv_pause = 1'b1; step();
    check_value("resumed_phase", int'(mif.phase), P_PLAY);
    drv_pause = 1'b0;
    wait_secs(7, 40);
    drv_start = 1'b0; step();
    drv_start = 1'b1; step();
    check_value("abort_phase", int'(mif.phase), P_IDLE);

`ifdef MATCH_OVERTIME_EN
    drv_tied = 1'b1;
    start_match(3);
    wait_phase(P_OT, 60, n);
    check_value("ot_seconds", int'(mif.seconds), OT);
    wait_phase(P_GO, 60, n);
    check_value("ot_timeout", int'(mif.timeout), 1);
    drv_tied = 1'b0;
    wait_phase(P_IDLE, 40, n);
`endif

    // Random traffic with an asynchronous reset dropped in mid-run.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) drv_start = ~drv_start;
      if ($urandom_range(0, 11) == 0) drv_pause = ~drv_pause;
      drv_win  = ($urandom_range(0, 59) == 0);
      drv_tied = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) drv_dsel = SEC_W'($urandom_range(0, 12));
      step();
      if (i == 1500) begin
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        model_reset();
        repeat (2) @(negedge clk_26);
        check_reset_values("async_hold");
        #1 reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
